// File: rtl/darkmm_arb.sv
// Two-port round-robin arbiter and access sequencer for the darkriscv memory-map bus.
// Serves one registered transaction at a time and adds per-region wait states before the acknowledge.
module darkmm_arb #(
    parameter int unsigned ROM_WS   = 0,
    parameter int unsigned FLASH_WS = 3,
    parameter int unsigned RAM_WS   = 1
) (
    input  logic        XCLK,
    input  logic        XRES,
    input  logic        I_REQ,
    input  logic [31:0] I_ADDR,
    output logic [31:0] I_DATA,
    output logic        I_ACK,
    input  logic        D_REQ,
    input  logic        D_WR,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_DATAI,
    output logic [31:0] D_DATAO,
    output logic        D_ACK,
    output logic        M_EN,
    output logic        M_RD,
    output logic        M_WR,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_DATAO,
    input  logic [31:0] M_DATAI,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        grant, grant_d;
    logic        last_d;
    logic [3:0]  cnt;
    logic [31:0] req_addr;

    function automatic logic [3:0] wait_for(input logic [2:0] region);
        case (region)
            3'b000:  return 4'(ROM_WS);
            3'b001:  return 4'(FLASH_WS);
            default: return 4'(RAM_WS);
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (I_REQ || D_REQ) begin
                    grant     = 1'b1;
                    grant_d   = D_REQ && (!I_REQ || !last_d);
                    state_nxt = ACCESS;
                end
            end
            ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign req_addr = grant_d ? D_ADDR : I_ADDR;
    assign BUSY     = (state != IDLE);

    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) state <= IDLE;
        else      state <= state_nxt;
    end

    // last_d doubles as the port id of the transaction in flight, since it is updated at grant.
    always_ff @(posedge XCLK or posedge XRES) begin
        if (XRES) begin
            last_d  <= 1'b1;
            cnt     <= 4'd0;
            M_EN    <= 1'b0;
            M_RD    <= 1'b0;
            M_WR    <= 1'b0;
            M_ADDR  <= 32'd0;
            M_DATAO <= 32'd0;
            I_DATA  <= 32'd0;
            D_DATAO <= 32'd0;
            I_ACK   <= 1'b0;
            D_ACK   <= 1'b0;
        end else if (grant) begin
            last_d  <= grant_d;
            cnt     <= wait_for(req_addr[31:29]);
            M_EN    <= 1'b1;
            M_RD    <= !(grant_d && D_WR);
            M_WR    <= grant_d && D_WR;
            M_ADDR  <= req_addr;
            M_DATAO <= grant_d ? D_DATAI : 32'd0;
        end else if (state == ACCESS) begin
            if (cnt == 4'd0) begin
                M_EN  <= 1'b0;
                M_RD  <= 1'b0;
                M_WR  <= 1'b0;
                I_ACK <= !last_d;
                D_ACK <= last_d;
                if (!M_WR) begin
                    if (last_d) D_DATAO <= M_DATAI;
                    else        I_DATA  <= M_DATAI;
                end
            end else begin
                cnt <= cnt - 4'd1;
            end
        end else if (state == RESP) begin
            I_ACK <= 1'b0;
            D_ACK <= 1'b0;
        end
    end

endmodule

// File: doc/darkmm_arb.md
# darkmm_arb

Two-port arbiter and access sequencer sitting in front of the darkriscv memory-map decoder. Shares the single downstream memory-map bus between the instruction-fetch port (read-only) and the data port (read/write). Grants in round-robin order, drives one registered bus transaction at a time, and inserts per-region wait states for ocrom, flash and edram. Each access completes with a one-cycle acknowledge and registered read data.

## Interface

Parameters:
- ROM_WS, 0, wait states for ocrom region (0..15)
- FLASH_WS, 3, wait states for flash region (0..15)
- RAM_WS, 1, wait states for edram region (0..15)

Ports (one clock; reset is asynchronous and active-high):
- XCLK  in  1  clock, rising edge
- XRES  in  1  asynchronous active-high reset
- I_REQ  in  1  instruction-port request; held until I_ACK
- I_ADDR  in  32  instruction address; stable while I_REQ
- I_DATA  out  32  instruction read data, registered
- I_ACK  out  1  one-cycle completion pulse for instruction port
- D_REQ  in  1  data-port request; held until D_ACK
- D_WR  in  1  1 = write, 0 = read; stable while D_REQ
- D_ADDR  in  32  data address; stable while D_REQ
- D_DATAI  in  32  write data; stable while D_REQ
- D_DATAO  out  32  data read data, registered
- D_ACK  out  1  one-cycle completion pulse for data port
- M_EN  out  1  downstream enable (to decoder `enable`)
- M_RD  out  1  downstream read strobe
- M_WR  out  1  downstream write strobe
- M_ADDR  out  32  downstream address
- M_DATAO  out  32  downstream write data
- M_DATAI  in  32  downstream read data (decoder output)
- BUSY  out  1  high whenever state != IDLE

## Operation

- States: IDLE, ACCESS, RESP.
- IDLE: if no request, stay. If exactly one of I_REQ/D_REQ, grant it. If both, grant the port not granted last (last_grant register, reset value = D, so I wins the first tie). On grant: latch port id, address, write flag (I port always read), write data; load wait counter; update last_grant; go ACCESS.
- Region / wait selection from address bits [31:29]: 3'b000 -> ROM_WS; 3'b001 -> FLASH_WS; any other -> RAM_WS. Counter 4 bits.
- ACCESS: M_EN=1, M_RD=~wr, M_WR=wr, M_ADDR/M_DATAO from latched values, all registered and constant for the whole state. Counter decrements each cycle; when counter == 0 in ACCESS: capture M_DATAI into I_DATA or D_DATAO (reads only; writes leave both unchanged), go RESP.
- RESP: M_EN/M_RD/M_WR = 0; assert ACK of granted port for exactly this cycle; go IDLE.
- The non-granted port's request waits; its signals are not sampled until granted.
- Requester may drop REQ in the cycle after ACK; REQ still high in IDLE is treated as a new request.
- I_DATA / D_DATAO hold their last captured values until next read by the same port.

## Timing

- Reset (async, XRES=1): state=IDLE, last_grant=D, counter=0, M_EN=M_RD=M_WR=0, M_ADDR=M_DATAO=0, I_DATA=D_DATAO=0, I_ACK=D_ACK=0, BUSY=0.
- Reset mid-access: bus strobes drop immediately; no ACK issued; aborted request is re-arbitrated after reset release if still asserted.
- ACCESS lasts WS+1 cycles; M_DATAI sampled at the final ACCESS edge.
- Latency, REQ high in IDLE (edge t) to ACK high: ACK visible in cycle t+WS+2; read data valid together with ACK and held afterwards.
- Back-to-back throughput: one access per WS+3 cycles (IDLE, WS+1 ACCESS, RESP).
- Both ports continuously requesting: grants strictly alternate I, D, I, D...
- Requests arriving during ACCESS/RESP are not seen until the next IDLE.

## Test plan

- Reset: assert XRES mid-ACCESS with D write to 0x4000_0010 -> M_EN/M_WR low asynchronously, no D_ACK, all outputs at reset values; after release, held D_REQ is re-served.
- Single I read of 0x0000_0100, ROM_WS=0, M_DATAI=0x0000_0013 -> M_EN high 1 cycle, I_ACK 2 cycles after grant, I_DATA=0x0000_0013.
- Flash read D_ADDR=0x2000_0004, FLASH_WS=3, M_DATAI=0xDEAD_BEEF -> M_EN high 4 cycles, D_ACK at t+5, D_DATAO=0xDEAD_BEEF, I_DATA unchanged.
- D write 0x4000_0020 data 0x1234_5678, RAM_WS=1 -> M_WR high 2 cycles, M_DATAO=0x1234_5678, M_RD=0, D_ACK at t+3, D_DATAO unchanged.
- Simultaneous I_REQ and D_REQ held for 4 transactions after reset -> grant order I, D, I, D; each ACK one cycle wide; never both ACKs in the same cycle.
- Region boundary: D reads at 0x1FFF_FFFC and 0x2000_0000 -> ACCESS lengths 1 and 4 cycles respectively (defaults).
